// File: rtl/fifo_rd_stream_adapter.sv
// Read-side master for a 1-cycle-latency FIFO, re-presenting words as a valid/ready stream.
// Optional beat counter enabled by defining FIFO_RD_ADAPTER_STATS_EN.
module fifo_rd_stream_adapter #(
    parameter int unsigned DW        = 32,
    parameter int unsigned BUF_DEPTH = 3
`ifdef FIFO_RD_ADAPTER_STATS_EN
    ,
    parameter int unsigned CNT_W     = 16
`endif
) (
    input  logic                           clk_i,
    input  logic                           arstn_i,
    input  logic                           flush_i,
    output logic                           fifo_req_o,
    input  logic                           fifo_valid_i,
    input  logic [DW-1:0]                  fifo_data_i,
    input  logic                           fifo_empty_i,
    output logic                           m_valid_o,
    output logic [DW-1:0]                  m_data_o,
    input  logic                           m_ready_i,
    output logic [$clog2(BUF_DEPTH+1)-1:0] level_o,
    output logic                           err_o
`ifdef FIFO_RD_ADAPTER_STATS_EN
    ,
    output logic [CNT_W-1:0]               beats_o
`endif
);

    localparam int unsigned LW = $clog2(BUF_DEPTH + 1);
    localparam int unsigned PW = $clog2(BUF_DEPTH);
    localparam logic [LW:0] DepthL = (LW+1)'(BUF_DEPTH);

    logic [DW-1:0] mem_q [BUF_DEPTH];
    logic [PW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [LW-1:0] level_q, level_d;
    logic          inflight_q, inflight_d;
    logic          err_q, err_d;
    logic          run_q;
    logic [LW:0]   credit_used;
    logic          push, pop;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(BUF_DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    always_comb begin
        credit_used = {1'b0, level_q} + {{LW{1'b0}}, inflight_q};
        // run_q keeps the request low while in reset without using the reset as data
        fifo_req_o  = run_q && !fifo_empty_i && !flush_i && (credit_used < DepthL);
        m_valid_o   = (level_q != '0);
        m_data_o    = mem_q[rd_ptr_q];
        level_o     = level_q;
        err_o       = err_q;

        push        = fifo_valid_i && inflight_q && !flush_i;
        pop         = m_valid_o && m_ready_i && !flush_i;

        level_d     = level_q;
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        inflight_d  = fifo_req_o;
        // Valid without a request, or a request with no returned word, are both errors
        err_d       = err_q | (fifo_valid_i ^ inflight_q);

        if (push) wr_ptr_d = ptr_inc(wr_ptr_q);
        if (pop)  rd_ptr_d = ptr_inc(rd_ptr_q);
        case ({push, pop})
            2'b10:   level_d = level_q + LW'(1);
            2'b01:   level_d = level_q - LW'(1);
            default: level_d = level_q;
        endcase

        if (flush_i) begin
            level_d  = '0;
            wr_ptr_d = '0;
            rd_ptr_d = '0;
        end
    end

    always_ff @(posedge clk_i or negedge arstn_i) begin
        if (!arstn_i) begin
            for (int i = 0; i < int'(BUF_DEPTH); i++) mem_q[i] <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            level_q    <= '0;
            inflight_q <= 1'b0;
            err_q      <= 1'b0;
            run_q      <= 1'b0;
        end else begin
            if (push) mem_q[wr_ptr_q] <= fifo_data_i;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            level_q    <= level_d;
            inflight_q <= inflight_d;
            err_q      <= err_d;
            run_q      <= 1'b1;
        end
    end

`ifdef FIFO_RD_ADAPTER_STATS_EN
    logic [CNT_W-1:0] beats_q, beats_d;

    always_comb begin
        beats_d = beats_q;
        if (flush_i)                    beats_d = '0;
        else if (pop && beats_q != '1)  beats_d = beats_q + CNT_W'(1);
    end

    always_ff @(posedge clk_i or negedge arstn_i) begin
        if (!arstn_i) beats_q <= '0;
        else          beats_q <= beats_d;
    end

    assign beats_o = beats_q;
`endif

endmodule

// File: tb/tb_fifo_rd_stream_adapter.sv
// Scoreboard bench for fifo_rd_stream_adapter: BUF_DEPTH=3 (dut a) and BUF_DEPTH=2 (dut b),
// each fed by a behavioural 1-cycle-latency FIFO model.
module tb_fifo_rd_stream_adapter;

    logic clk = 1'b0;
    logic arstn = 1'b0;
    always #5 clk = ~clk;

    logic        a_flush, a_req, a_fvalid, a_empty, a_mvalid, a_mready, a_err, force_a;
    logic [31:0] a_fdata, a_mdata;
    logic [1:0]  a_level;
    logic        b_flush, b_req, b_fvalid, b_empty, b_mvalid, b_mready, b_err;
    logic [31:0] b_fdata, b_mdata;
    logic [1:0]  b_level;
`ifdef FIFO_RD_ADAPTER_STATS_EN
    logic [15:0] a_beats, b_beats;
`endif

    fifo_rd_stream_adapter #(.DW(32), .BUF_DEPTH(3)) u_dut_a (
        .clk_i        (clk),
        .arstn_i      (arstn),
        .flush_i      (a_flush),
        .fifo_req_o   (a_req),
        .fifo_valid_i (a_fvalid),
        .fifo_data_i  (a_fdata),
        .fifo_empty_i (a_empty),
        .m_valid_o    (a_mvalid),
        .m_data_o     (a_mdata),
        .m_ready_i    (a_mready),
        .level_o      (a_level),
        .err_o        (a_err)
`ifdef FIFO_RD_ADAPTER_STATS_EN
        ,
        .beats_o      (a_beats)
`endif
    );

    fifo_rd_stream_adapter #(.DW(32), .BUF_DEPTH(2)) u_dut_b (
        .clk_i        (clk),
        .arstn_i      (arstn),
        .flush_i      (b_flush),
        .fifo_req_o   (b_req),
        .fifo_valid_i (b_fvalid),
        .fifo_data_i  (b_fdata),
        .fifo_empty_i (b_empty),
        .m_valid_o    (b_mvalid),
        .m_data_o     (b_mdata),
        .m_ready_i    (b_mready),
        .level_o      (b_level),
        .err_o        (b_err)
`ifdef FIFO_RD_ADAPTER_STATS_EN
        ,
        .beats_o      (b_beats)
`endif
    );

    int n_checks = 0;
    int n_pass   = 0;

    logic [31:0] fq_a[$], fq_b[$], sb_a[$], sb_b[$];
    int n_push_a = 0, n_pop_a = 0, n_push_b = 0, n_pop_b = 0;

    assign a_empty = (n_push_a == n_pop_a);
    assign b_empty = (n_push_b == n_pop_b);

    // FIFO models: word appears on valid/data the cycle after req
    always @(posedge clk or negedge arstn) begin
        if (!arstn) begin
            a_fvalid <= 1'b0;
            a_fdata  <= '0;
        end else if (a_req && fq_a.size() > 0) begin
            a_fvalid <= 1'b1;
            a_fdata  <= fq_a.pop_front();
            n_pop_a  <= n_pop_a + 1;
        end else begin
            a_fvalid <= force_a;
            a_fdata  <= 32'hDEAD_BEEF;
        end
    end

    always @(posedge clk or negedge arstn) begin
        if (!arstn) begin
            b_fvalid <= 1'b0;
            b_fdata  <= '0;
        end else if (b_req && fq_b.size() > 0) begin
            b_fvalid <= 1'b1;
            b_fdata  <= fq_b.pop_front();
            n_pop_b  <= n_pop_b + 1;
        end else begin
            b_fvalid <= 1'b0;
            b_fdata  <= 32'hDEAD_BEEF;
        end
    end

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, required 0x%0h", name, got, exp);
    endtask

    task automatic load_a(input logic [31:0] w, input bit expect_out);
        fq_a.push_back(w);
        n_push_a++;
        if (expect_out) sb_a.push_back(w);
    endtask

    task automatic load_b(input logic [31:0] w);
        fq_b.push_back(w);
        n_push_b++;
        sb_b.push_back(w);
    endtask

    // Stream monitors: every accepted beat must match the scoreboard head
    always @(negedge clk) begin
        if (arstn && a_mvalid && a_mready && !a_flush) begin
            if (sb_a.size() == 0) begin
                n_checks++;
                $display("FAIL beat_a: got 0x%0h, required no beat", a_mdata);
            end else begin
                chk("beat_a", a_mdata, sb_a.pop_front());
            end
        end
        if (arstn && b_mvalid && b_mready && !b_flush) begin
            if (sb_b.size() == 0) begin
                n_checks++;
                $display("FAIL beat_b: got 0x%0h, required no beat", b_mdata);
            end else begin
                chk("beat_b", b_mdata, sb_b.pop_front());
            end
        end
    end

    initial begin
        int reqs, runs, first_req, first_val, maxl, gaps, beats, last, bad;
        bit prev, found;
        a_flush = 0; a_mready = 0; force_a = 0;
        b_flush = 0; b_mready = 0;

        repeat (3) @(posedge clk);
        #1;
        chk("rst_req_a", a_req, 0);
        chk("rst_valid_a", a_mvalid, 0);
        chk("rst_data_a", a_mdata, 0);
        chk("rst_level_a", a_level, 0);
        chk("rst_err_a", a_err, 0);
        @(negedge clk) arstn = 1'b1;
        repeat (2) @(posedge clk);
        #1;

        // Test 1: 8 words, ready held high
        for (int i = 0; i < 8; i++) load_a(32'h10 + i, 1'b1);
        a_mready = 1;
        reqs = 0; runs = 0; first_req = -1; first_val = -1; maxl = 0; prev = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (a_req) reqs++;
            if (a_req && !prev) runs++;
            prev = a_req;
            if (a_req && first_req < 0) first_req = i;
            if (a_mvalid && first_val < 0) first_val = i;
            if (int'(a_level) > maxl) maxl = int'(a_level);
        end
        chk("t1_req_count", reqs, 8);
        chk("t1_req_contiguous", runs, 1);
        chk("t1_latency", first_val - first_req, 2);
        chk("t1_level_le2", maxl <= 2, 1);
        chk("t1_err", a_err, 0);
        chk("t1_all_delivered", sb_a.size(), 0);

        // Test 2: same with ready low, then release
        @(posedge clk); #1;
        a_mready = 0;
        for (int i = 0; i < 8; i++) load_a(32'h20 + i, 1'b1);
        reqs = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (a_req) reqs++;
        end
        chk("t2_req_count", reqs, 3);
        chk("t2_level", a_level, 3);
        chk("t2_valid_held", a_mvalid, 1);
        chk("t2_data_held", a_mdata, 32'h20);
        chk("t2_req_stalled", a_req, 0);
        @(posedge clk); #1;
        a_mready = 1;
        gaps = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (i < 8 && !a_mvalid) gaps++;
        end
        chk("t2_no_gap", gaps, 0);
        chk("t2_all_delivered", sb_a.size(), 0);

        // Test 3: BUF_DEPTH=2, 4 words, ready high
        @(posedge clk); #1;
        b_mready = 1;
        for (int i = 0; i < 4; i++) load_b(32'h30 + i);
        reqs = 0; beats = 0; last = -1; maxl = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (b_req) reqs++;
            if (b_mvalid && b_mready) begin beats++; last = i; end
            if (int'(b_level) > maxl) maxl = int'(b_level);
        end
        chk("t3_req_count", reqs, 4);
        chk("t3_beats", beats, 4);
        chk("t3_last_beat_by_clk8", (last >= 0) && (last <= 8), 1);
        chk("t3_level_le2", maxl <= 2, 1);
        chk("t3_err", b_err, 0);
        chk("t3_all_delivered", sb_b.size(), 0);

        // Test 4: one word, ready toggling
        beats = 0; bad = 0; reqs = 0;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            if (i == 0) load_a(32'h40, 1'b1);
            a_mready = (i % 2 == 0);
            @(negedge clk);
            if (a_mvalid && a_mready) beats++;
            if (a_req) reqs++;
            if (a_empty && a_req) bad++;
        end
        chk("t4_beats", beats, 1);
        chk("t4_req_count", reqs, 1);
        chk("t4_req_while_empty", bad, 0);
        chk("t4_err", a_err, 0);
        chk("t4_all_delivered", sb_a.size(), 0);

        // Test 5: flush with level=2 and a word in flight
        @(posedge clk); #1;
        a_mready = 0;
        for (int i = 0; i < 3; i++) load_a(32'h60 + i, 1'b0);
        found = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (a_level == 2) begin found = 1; break; end
        end
        chk("t5_level2_reached", found, 1);
        chk("t5_word_in_flight", a_fvalid, 1);
        a_flush = 1;
        @(posedge clk); #1;
        a_flush = 0;
        @(negedge clk);
        chk("t5_level_flushed", a_level, 0);
        chk("t5_valid_flushed", a_mvalid, 0);
        chk("t5_err", a_err, 0);
        @(posedge clk); #1;
        load_a(32'hAA, 1'b1);
        a_mready = 1;
        repeat (8) @(negedge clk);
        chk("t5_aa_delivered", sb_a.size(), 0);
        chk("t5_err_after", a_err, 0);

        // Test 6: unsolicited valid, then async reset mid-stream
        @(posedge clk); #1;
        a_mready = 0;
        @(negedge clk) force_a = 1;
        @(posedge clk); #1;
        force_a = 0;
        @(negedge clk);
        chk("t6_err_not_yet", a_err, 0);
        @(negedge clk);
        chk("t6_err_set", a_err, 1);
        chk("t6_level_unchanged", a_level, 0);
        chk("t6_valid_unchanged", a_mvalid, 0);

        @(posedge clk); #1;
        a_mready = 1;
        for (int i = 0; i < 6; i++) load_a(32'h50 + i, 1'b1);
        repeat (4) @(posedge clk);
        #2 arstn = 1'b0;
        #1;
        chk("t6_rst_req", a_req, 0);
        chk("t6_rst_valid", a_mvalid, 0);
        chk("t6_rst_data", a_mdata, 0);
        chk("t6_rst_level", a_level, 0);
        chk("t6_rst_err", a_err, 0);
        sb_a.delete();
        fq_a.delete();
        n_push_a = n_pop_a;
        @(negedge clk) arstn = 1'b1;
        repeat (2) @(posedge clk);
        #1;

        // Five pops after reset
        for (int i = 0; i < 5; i++) load_a(32'h70 + i, 1'b1);
        repeat (12) @(negedge clk);
        chk("t7_all_delivered", sb_a.size(), 0);
        chk("t7_err", a_err, 0);
`ifdef FIFO_RD_ADAPTER_STATS_EN
        chk("t7_beats_a", a_beats, 5);
        chk("t7_beats_b_cleared", b_beats, 0);
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
